// File: rtl/sweep_pkg.sv
// Shared types and constants for the exhaustive pattern sweep sequencer.
package sweep_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE   = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_EMIT    = 3'd4,
        S_DONE    = 3'd5
    } sweep_state_t;

    // CRC-CCITT feedback taps; narrower signatures take the low bits.
    localparam logic [15:0] POLY = 16'h1021;

    // Record layout: pattern in the MSBs, response in the low out_w bits.
    function automatic logic [63:0] make_record(input logic [31:0] pat,
                                                input logic [31:0] resp,
                                                input int unsigned out_w);
        return ({32'b0, pat} << out_w) | {32'b0, resp};
    endfunction

endpackage

// File: rtl/sweep_misr.sv
// Multiple-input signature register compacting each accepted sweep record.
module sweep_misr
    import sweep_pkg::*;
#(
    parameter int SIG_W  = 16,
    parameter int DATA_W = 5
) (
    input  logic              CK,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [SIG_W-1:0]  sig
);

    localparam logic [SIG_W-1:0] POLY_W = SIG_W'(POLY);

    always_ff @(posedge CK or negedge reset_n) begin
        if (!reset_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= ({sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY_W : '0)) ^ SIG_W'(data);
        end
    end

endmodule

// File: rtl/pattern_sweep_ctrl.sv
// Walks a benchmark DUT through every input pattern, logs {pattern, response}
// records and compacts them into a MISR signature. GOLDEN_CMP_EN adds a golden compare.
module pattern_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 1,
    parameter int SIG_W  = 16
) (
    input  logic                  CK,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [N_IN-1:0]       pat_o,
    input  logic [OUT_W-1:0]      resp_i,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic [N_IN+OUT_W-1:0] rec_data,
    output logic                  busy,
    output logic                  done,
    output logic [SIG_W-1:0]      sig_o,
`ifdef GOLDEN_CMP_EN
    input  logic [SIG_W-1:0]      golden_sig,
    output logic                  mismatch,
`endif
    output sweep_state_t          dbg_state
);

    localparam int REC_W = N_IN + OUT_W;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN:0] LAST_IDX = {1'b0, {N_IN{1'b1}}};

    sweep_state_t     state, state_nxt;
    logic [N_IN:0]    idx;
    logic [CNT_W-1:0] cnt;
    logic             start_ok;
    logic             hs;
    logic             settle_end;

    // Handshake: a record transfers on a rising edge where rec_valid && rec_ready;
    // while rec_valid is high and rec_ready low, rec_data is held unchanged.
    assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
    assign hs         = (state == S_EMIT) && rec_valid && rec_ready;
    assign settle_end = (cnt == CNT_W'(SETTLE - 1));
    assign dbg_state  = state;

    always_ff @(posedge CK or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) state_nxt = S_DRIVE;
                S_DRIVE:        state_nxt = S_SETTLE;
                S_SETTLE:       if (settle_end) state_nxt = S_CAPTURE;
                S_CAPTURE:      state_nxt = S_EMIT;
                S_EMIT:         if (hs) state_nxt = (idx == LAST_IDX) ? S_DONE : S_DRIVE;
                default:        state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            cnt       <= '0;
            pat_o     <= '0;
            rec_valid <= 1'b0;
            rec_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            idx       <= '0;
            cnt       <= '0;
            pat_o     <= '0;
            rec_valid <= 1'b0;
            rec_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx  <= '0;
                        busy <= 1'b1;
                        done <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    pat_o <= idx[N_IN-1:0];
                    cnt   <= '0;
                end
                S_SETTLE: cnt <= cnt + 1'b1;
                S_CAPTURE: begin
                    rec_data  <= REC_W'(make_record(32'(pat_o), 32'(resp_i), OUT_W));
                    rec_valid <= 1'b1;
                end
                S_EMIT: begin
                    if (hs) begin
                        rec_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    sweep_misr #(
        .SIG_W (SIG_W),
        .DATA_W(REC_W)
    ) u_misr (
        .CK     (CK),
        .reset_n(reset_n),
        .clr    (abort || start_ok),
        .en     (hs && !abort),
        .data   (rec_data),
        .sig    (sig_o)
    );

`ifdef GOLDEN_CMP_EN
    // The signature is frozen while done is high, so the compare is stable.
    assign mismatch = done && (sig_o != golden_sig);
`endif

endmodule
